// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared types and constants for the UART receive path.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int         OVERSAMPLE = 16;
    localparam int         SCNT_W     = $clog2(OVERSAMPLE);
    localparam logic [3:0] MID_TICK   = 4'd7;
    localparam logic [3:0] LAST_TICK  = 4'd15;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module : uart_sync2
// Brief  : Two-flop synchronizer for idle-high async lines (RX, CTS, RTS).
// Rev    : 1.0  initial release
// ============================================================================
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_core
// Brief  : UART receiver, 16x oversampled, bit-centre sampling, 1-clk result.
// Rev    : 1.0  initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam logic [3:0] c_last_bit = 4'(DATA_BITS - 1);
    localparam logic       c_par_en   = (PARITY_EN != 0);
    localparam logic       c_par_odd  = (PARITY_ODD != 0);

    logic                 w_rx_s;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [SCNT_W-1:0]    r_s_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;

    logic w_cnt_clr;
    logic w_bit_clr;
    logic w_shift_en;
    logic w_par_latch;
    logic w_done;
    logic w_par_err;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_in),
        .q     (w_rx_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        w_bit_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_par_latch = 1'b0;
        w_done      = 1'b0;
        if (rx_tick) begin
            case (r_state)
                IDLE: begin
                    w_cnt_clr = 1'b1;
                    if (!w_rx_s) w_state_nxt = START;
                end
                START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (r_s_cnt == MID_TICK) begin
                        w_cnt_clr = 1'b1;
                        if (!w_rx_s) begin
                            w_state_nxt = DATA;
                            w_bit_clr   = 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (r_s_cnt == LAST_TICK) begin
                        w_cnt_clr  = 1'b1;
                        w_shift_en = 1'b1;
                        if (r_bit_cnt == c_last_bit)
                            w_state_nxt = c_par_en ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (r_s_cnt == LAST_TICK) begin
                        w_cnt_clr   = 1'b1;
                        w_par_latch = 1'b1;
                        w_state_nxt = STOP;
                    end
                end
                STOP: begin
                    if (r_s_cnt == LAST_TICK) begin
                        w_cnt_clr   = 1'b1;
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_par_err = c_par_en & ((^r_shift ^ r_par) != c_par_odd);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_cnt      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (rx_tick) begin
                r_s_cnt <= w_cnt_clr ? '0 : r_s_cnt + 1'b1;
                if (w_bit_clr) r_bit_cnt <= '0;
                // LSB arrives first, so shifting right leaves it in bit 0.
                if (w_shift_en) begin
                    r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (w_par_latch) r_par <= w_rx_s;
                if (w_done) begin
                    r_rx_data    <= r_shift;
                    r_frame_err  <= ~w_rx_s;
                    r_parity_err <= w_par_err;
                    r_rx_valid   <= 1'b1;
                end
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign busy       = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_core
// Brief  : Directed self-checking bench for uart_rx_core (8N1 and 8E1 instances).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_rx_core;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       rx_tick = 1'b0;
    logic       rx_in   = 1'b1;
    logic       rx_in_p = 1'b1;
    logic [7:0] rx_data,    rx_data_p;
    logic       rx_valid,   rx_valid_p;
    logic       frame_err,  frame_err_p;
    logic       parity_err, parity_err_p;
    logic       busy,       busy_p;

    int checks = 0;
    int errors = 0;

    uart_rx_core #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .rx_tick(rx_tick), .rx_in(rx_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .parity_err(parity_err), .busy(busy)
    );

    uart_rx_core #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .reset(reset), .rx_tick(rx_tick), .rx_in(rx_in_p),
        .rx_data(rx_data_p), .rx_valid(rx_valid_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    int tdiv = 0;
    always @(negedge clk) begin
        tdiv    = (tdiv + 1) % 4;
        rx_tick = (tdiv == 0);
    end

    // Pulse recorder for both instances
    int         cyc = 0, vcnt = 0, wide = 0, pcnt = 0;
    logic       prev_v = 1'b0;
    logic [7:0] vdata [16];
    logic       vferr [16];
    logic       vperr [16];
    int         vtime [16];
    logic [7:0] pdata = 8'h00;
    logic       pperr = 1'b0, pferr = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (rx_valid) begin
            if (vcnt < 16) begin
                vdata[vcnt] = rx_data;
                vferr[vcnt] = frame_err;
                vperr[vcnt] = parity_err;
                vtime[vcnt] = cyc;
            end
            vcnt++;
            if (prev_v) wide++;
        end
        prev_v = rx_valid;
        if (rx_valid_p) begin
            pcnt++;
            pdata = rx_data_p;
            pperr = parity_err_p;
            pferr = frame_err_p;
        end
    end

    task automatic send_bit(input logic b, input logic sel);
        if (sel) rx_in_p = b;
        else     rx_in   = b;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic sel, input logic use_par, input logic par);
        send_bit(1'b0, sel);
        for (int i = 0; i < 8; i++) send_bit(d[i], sel);
        if (use_par) send_bit(par, sel);
        send_bit(stop, sel);
        if (sel) rx_in_p = 1'b1;
        else     rx_in   = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        repeat (64 * n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        idle_bits(1);
    endtask

    task automatic test_8n1;
        int v0 = vcnt;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_bits(2);
        checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL a5_count: got %0d expected %0d", vcnt, v0 + 1); end
        checks++; if (vdata[v0] !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h expected a5", vdata[v0]); end
        checks++; if (vferr[v0] !== 1'b0) begin errors++; $display("FAIL a5_ferr: got %b expected 0", vferr[v0]); end
        checks++; if (vperr[v0] !== 1'b0) begin errors++; $display("FAIL a5_perr: got %b expected 0", vperr[v0]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy: got %b expected 0", busy); end
    endtask

    task automatic test_glitch;
        int v0 = vcnt;
        rx_in = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
        repeat (4) @(negedge clk);
        rx_in = 1'b1;
        repeat (48) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_idle: got %b expected 0", busy); end
        idle_bits(2);
        checks++; if (vcnt !== v0) begin errors++; $display("FAIL glitch_count: got %0d expected %0d", vcnt, v0); end
    endtask

    task automatic test_frame_err;
        int v0 = vcnt;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        idle_bits(2);
        checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL ferr_count: got %0d expected %0d", vcnt, v0 + 1); end
        checks++; if (vdata[v0] !== 8'h3C) begin errors++; $display("FAIL ferr_data: got %h expected 3c", vdata[v0]); end
        checks++; if (vferr[v0] !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", vferr[v0]); end
    endtask

    task automatic test_parity;
        int p0 = pcnt;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
        idle_bits(1);
        checks++; if (pcnt !== p0 + 1) begin errors++; $display("FAIL par_bad_count: got %0d expected %0d", pcnt, p0 + 1); end
        checks++; if (pdata !== 8'h07) begin errors++; $display("FAIL par_bad_data: got %h expected 07", pdata); end
        checks++; if (pperr !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b expected 1", pperr); end
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
        idle_bits(1);
        checks++; if (pcnt !== p0 + 2) begin errors++; $display("FAIL par_good_count: got %0d expected %0d", pcnt, p0 + 2); end
        checks++; if (pperr !== 1'b0) begin errors++; $display("FAIL par_good_flag: got %b expected 0", pperr); end
        checks++; if (pferr !== 1'b0) begin errors++; $display("FAIL par_good_ferr: got %b expected 0", pferr); end
    endtask

    task automatic test_reset_mid;
        int v0 = vcnt;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        rx_in = 1'b1;
        repeat (32) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_data_clr: got %h expected 00", rx_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL mid_ferr_clr: got %b expected 0", frame_err); end
        idle_bits(5);
        checks++; if (vcnt !== v0) begin errors++; $display("FAIL mid_no_valid: got %0d expected %0d", vcnt, v0); end
        send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_bits(1);
        checks++; if (vcnt !== v0 + 1) begin errors++; $display("FAIL mid_55_count: got %0d expected %0d", vcnt, v0 + 1); end
        checks++; if (vdata[v0] !== 8'h55) begin errors++; $display("FAIL mid_55_data: got %h expected 55", vdata[v0]); end
        checks++; if (vferr[v0] !== 1'b0) begin errors++; $display("FAIL mid_55_ferr: got %b expected 0", vferr[v0]); end
    endtask

    task automatic test_back_to_back;
        int v0 = vcnt;
        int gap;
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        idle_bits(2);
        checks++; if (vcnt !== v0 + 2) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", vcnt, v0 + 2); end
        if (v0 + 1 < 16) begin
            gap = vtime[v0 + 1] - vtime[v0];
            checks++; if (vdata[v0] !== 8'h00) begin errors++; $display("FAIL b2b_data0: got %h expected 00", vdata[v0]); end
            checks++; if (vdata[v0 + 1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1: got %h expected ff", vdata[v0 + 1]); end
            checks++; if (vferr[v0] !== 1'b0 || vferr[v0 + 1] !== 1'b0) begin
                errors++; $display("FAIL b2b_ferr: got %b%b expected 00", vferr[v0], vferr[v0 + 1]); end
            checks++; if (gap < 632 || gap > 648) begin errors++; $display("FAIL b2b_gap: got %0d expected 640", gap); end
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_glitch();
        test_frame_err();
        test_parity();
        test_reset_mid();
        test_back_to_back();
        checks++; if (wide !== 0) begin errors++; $display("FAIL valid_width: got %0d wide pulses expected 0", wide); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
